// File: rtl/switch_route_pkg.sv
// Shared definitions for the switch ID-routing path: route codes, TLP type
// constants and the bit positions of the header fields the router decodes.
package switch_route_pkg;

    // Route code carried on rt_dest.
    typedef enum logic [1:0] {
        FWD_DSP    = 2'd0,
        CFG0_DSP   = 2'd1,
        PASS_LOCAL = 2'd2,
        UR         = 2'd3
    } route_e;

    // TLP type field values (DW0[28:24]) of interest.
    localparam logic [4:0] CFG0   = 5'b00100;
    localparam logic [4:0] CFG1   = 5'b00101;
    localparam logic [4:0] CPL    = 5'b01010;
    localparam logic [4:0] CPLD   = 5'b01011;
    localparam logic [4:0] MSG_ID = 5'b10010;

    // Field positions within the 96-bit header (DW0 = [95:64], DW2 = [31:0]).
    localparam int TYPE_MSB    = 92;
    localparam int TYPE_LSB    = 88;
    localparam int TGT_BUS_MSB = 31;
    localparam int TGT_BUS_LSB = 24;
    localparam int DEV_MSB     = 23;
    localparam int DEV_LSB     = 19;

    // Unsigned inclusive window test; an inverted window (sec > sub) is empty.
    function automatic logic bus_in_range(input logic [7:0] bus,
                                          input logic [7:0] sec,
                                          input logic [7:0] sub);
        return (bus >= sec) && (bus <= sub);
    endfunction

endpackage

// File: rtl/dsp_route_classify.sv
// Combinational route decision for one downstream-bound TLP header against a
// captured secondary/subordinate bus window. Type1 config requests aimed at
// the secondary bus itself are rewritten to Type0.
module dsp_route_classify
    import switch_route_pkg::*;
#(
    parameter int HDR_W = 96
) (
    input  logic [HDR_W-1:0] i_hdr,
    input  logic [7:0]       i_sec_bus,
    input  logic [7:0]       i_sub_bus,
    output route_e           o_route,
    output logic [HDR_W-1:0] o_hdr
);

    logic [4:0] w_type;
    logic [7:0] w_tgt_bus;
    logic [4:0] w_dev;
    logic       w_in_range;
    logic       w_is_sec;

    assign w_type     = i_hdr[TYPE_MSB:TYPE_LSB];
    assign w_tgt_bus  = i_hdr[TGT_BUS_MSB:TGT_BUS_LSB];
    assign w_dev      = i_hdr[DEV_MSB:DEV_LSB];
    assign w_in_range = bus_in_range(w_tgt_bus, i_sec_bus, i_sub_bus);
    assign w_is_sec   = (w_tgt_bus == i_sec_bus);

    // Pick the route from the TLP type and the bus window; only the
    // Type1-to-Type0 conversion modifies the header.
    always_comb begin
        o_route = PASS_LOCAL;
        o_hdr   = i_hdr;
        case (w_type)
            CFG1: begin
                if (w_is_sec) begin
                    if (w_dev == 5'd0) begin
                        o_route                    = CFG0_DSP;
                        o_hdr[TYPE_MSB:TYPE_LSB]   = CFG0;
                    end else begin
                        o_route = UR;
                    end
                end else if (w_in_range) begin
                    o_route = FWD_DSP;
                end else begin
                    o_route = UR;
                end
            end
            CPL, CPLD, MSG_ID: begin
                o_route = w_in_range ? FWD_DSP : PASS_LOCAL;
            end
            default: begin
                o_route = PASS_LOCAL;
            end
        endcase
    end

endmodule

// File: rtl/dsp_id_route_decoder.sv
// ID-routing decoder for downstream-bound headers at the DSP side of the
// two-port switch. Two register stages: stage1 captures the header with a
// snapshot of sec/sub, stage2 holds the classified result and drives rt_*.
// Optional per-route statistics counters: define DSP_ROUTE_STATS_EN.
//
// Handshakes: a transfer happens on a cycle where valid & ready are both 1.
// A producer holds valid and data steady until that cycle; ready may depend
// combinationally on the consumer's ready (hdr_in_ready follows rt_ready).
module dsp_id_route_decoder
    import switch_route_pkg::*;
#(
    parameter int HDR_W  = 96,
    parameter int STAT_W = 16
) (
    input  logic                dsp_user_clk,
    input  logic                dsp_user_reset,
    input  logic                hdr_in_valid,
    output logic                hdr_in_ready,
    input  logic [HDR_W-1:0]    hdr_in_data,
    input  logic [7:0]          dsp_pri_bus,
    input  logic [7:0]          dsp_sec_bus,
    input  logic [7:0]          dsp_sub_bus,
    input  logic                all_bus_numbers_ready,
    output logic                rt_valid,
    input  logic                rt_ready,
    output logic [HDR_W-1:0]    rt_hdr,
    output logic [1:0]          rt_dest,
    output logic [4*STAT_W-1:0] stat_cnt
);

    logic             r_s1_valid;
    logic [HDR_W-1:0] r_s1_hdr;
    logic [7:0]       r_s1_sec;
    logic [7:0]       r_s1_sub;

    logic             r_s2_valid;
    logic [HDR_W-1:0] r_s2_hdr;
    route_e           r_s2_dest;

    logic             w_s2_pop;
    logic             w_s1_adv;
    logic             w_accept;
    route_e           w_cls_route;
    logic [HDR_W-1:0] w_cls_hdr;

    // The primary bus is carried for visibility only; routing never uses it.
    logic w_unused_pri;
    assign w_unused_pri = ^dsp_pri_bus;

    assign w_s2_pop     = r_s2_valid & rt_ready;
    assign w_s1_adv     = r_s1_valid & (~r_s2_valid | w_s2_pop);
    assign hdr_in_ready = all_bus_numbers_ready & ~dsp_user_reset
                        & (~r_s1_valid | w_s1_adv);
    assign w_accept     = hdr_in_valid & hdr_in_ready;

    // Stage1: capture header and the bus window seen in the accept cycle.
    always_ff @(posedge dsp_user_clk) begin
        if (dsp_user_reset) begin
            r_s1_valid <= 1'b0;
            r_s1_hdr   <= '0;
            r_s1_sec   <= '0;
            r_s1_sub   <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_hdr   <= hdr_in_data;
            r_s1_sec   <= dsp_sec_bus;
            r_s1_sub   <= dsp_sub_bus;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    dsp_route_classify #(
        .HDR_W (HDR_W)
    ) u_classify (
        .i_hdr     (r_s1_hdr),
        .i_sec_bus (r_s1_sec),
        .i_sub_bus (r_s1_sub),
        .o_route   (w_cls_route),
        .o_hdr     (w_cls_hdr)
    );

    // Stage2: hold the decision until downstream takes it.
    always_ff @(posedge dsp_user_clk) begin
        if (dsp_user_reset) begin
            r_s2_valid <= 1'b0;
            r_s2_hdr   <= '0;
            r_s2_dest  <= FWD_DSP;
        end else if (w_s1_adv) begin
            r_s2_valid <= 1'b1;
            r_s2_hdr   <= w_cls_hdr;
            r_s2_dest  <= w_cls_route;
        end else if (w_s2_pop) begin
            r_s2_valid <= 1'b0;
        end
    end

    assign rt_valid = r_s2_valid;
    assign rt_hdr   = r_s2_hdr;
    assign rt_dest  = r_s2_dest;

`ifdef DSP_ROUTE_STATS_EN
    localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

    logic [STAT_W-1:0] r_stat [4];

    // Saturating per-route handshake counters, cleared only by reset.
    always_ff @(posedge dsp_user_clk) begin
        if (dsp_user_reset) begin
            for (int i = 0; i < 4; i++) begin
                r_stat[i] <= '0;
            end
        end else if (w_s2_pop && (r_stat[r_s2_dest] != '1)) begin
            r_stat[r_s2_dest] <= r_stat[r_s2_dest] + STAT_ONE;
        end
    end

    assign stat_cnt = {r_stat[3], r_stat[2], r_stat[1], r_stat[0]};
`else
    assign stat_cnt = '0;
`endif

endmodule
